// File: rtl/vdma_fwft_axis_packer.sv
// Pops pixels from an FWFT FIFO and emits one AXI4-Stream video frame
// (tuser on first pixel, tlast at end of line) with frame-done and underrun status.
module vdma_fwft_axis_packer #(
    parameter int DWIDTH = 24,
    parameter int HBITS  = 12,
    parameter int VBITS  = 12
) (
    input  logic              clk,
    input  logic              reset_rclk_top,
    input  logic              frame_start,
    input  logic              frame_abort,
    input  logic [HBITS-1:0]  hres,
    input  logic [VBITS-1:0]  vres,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t             r_state, w_state_nxt;
    logic [HBITS-1:0]   r_hres, r_hcnt;
    logic [VBITS-1:0]   r_vres, r_vcnt;
    logic [DWIDTH-1:0]  r_tdata;
    logic               r_tvalid, r_tuser, r_tlast;
    logic               r_done, r_underrun, r_loaded;

    logic w_ld, w_accept, w_start_ok, w_start_zero, w_hlast, w_vlast, w_underrun_set;

    assign w_accept       = r_tvalid & m_axis_tready;
    assign w_start_ok     = frame_start & (r_state == S_IDLE) & (hres != '0) & (vres != '0);
    assign w_start_zero   = frame_start & (r_state == S_IDLE) & ((hres == '0) | (vres == '0));
    // Abort wins over a load so no pixel is popped into a frame being abandoned.
    assign w_ld           = (r_state == S_ACTIVE) & ~fifo_empty & (~r_tvalid | m_axis_tready)
                            & ~frame_abort;
    assign w_hlast        = (r_hcnt == r_hres - HBITS'(1));
    assign w_vlast        = (r_vcnt == r_vres - VBITS'(1));
    assign w_underrun_set = (r_state == S_ACTIVE) & r_loaded & fifo_empty
                            & (~r_tvalid | m_axis_tready);

    assign fifo_rd_en    = w_ld;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tlast  = r_tlast;
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = r_done;
    assign underrun      = r_underrun;

    always_ff @(posedge clk or negedge reset_rclk_top) begin
        if (!reset_rclk_top) r_state <= S_IDLE;
        else                 r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok)              w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_ld & w_hlast & w_vlast) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_accept)                w_state_nxt = S_IDLE;
            default:                               w_state_nxt = S_IDLE;
        endcase
        if (frame_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_rclk_top) begin
        if (!reset_rclk_top) begin
            r_hres     <= '0;
            r_vres     <= '0;
            r_hcnt     <= '0;
            r_vcnt     <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tuser    <= 1'b0;
            r_tlast    <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_loaded   <= 1'b0;
        end else if (frame_abort) begin
            r_hcnt   <= '0;
            r_vcnt   <= '0;
            r_tvalid <= 1'b0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
            r_done   <= 1'b0;
            r_loaded <= 1'b0;
        end else begin
            r_done <= w_start_zero | (w_accept & (r_state == S_DRAIN));
            if (w_start_ok) begin
                r_hres     <= hres;
                r_vres     <= vres;
                r_hcnt     <= '0;
                r_vcnt     <= '0;
                r_underrun <= 1'b0;
                r_loaded   <= 1'b0;
            end else if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end
            if (w_ld) begin
                r_tdata  <= fifo_dout;
                r_tvalid <= 1'b1;
                r_tuser  <= (r_hcnt == '0) & (r_vcnt == '0);
                r_tlast  <= w_hlast;
                r_loaded <= 1'b1;
                if (w_hlast) begin
                    r_hcnt <= '0;
                    r_vcnt <= r_vcnt + VBITS'(1);
                end else begin
                    r_hcnt <= r_hcnt + HBITS'(1);
                end
            end else if (w_accept) begin
                r_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vdma_fwft_axis_packer.sv
// Cycle-based bench: FWFT FIFO model plus expected-beat scoreboard, a frame
// table for the main cases and hand sequences for zero-res, abort and reset.
module tb_vdma_fwft_axis_packer;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset_rclk_top;
    logic          frame_start, frame_abort;
    logic [11:0]   hres;
    logic [11:0]   vres;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic          busy, frame_done, underrun;

    vdma_fwft_axis_packer #(.DWIDTH(DW), .HBITS(12), .VBITS(12)) dut (
        .clk(clk), .reset_rclk_top(reset_rclk_top),
        .frame_start(frame_start), .frame_abort(frame_abort),
        .hres(hres), .vres(vres),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .frame_done(frame_done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    typedef struct {
        int            h;
        int            v;
        logic [3:0]    pat;
        int            stall;
        bit            exp_ur;
        logic [DW-1:0] base;
    } vec_t;

    logic [DW-1:0] fifo_q[$];
    beat_t         exp_q[$];
    vec_t          vecs[5];

    int         n_cmp = 0, n_err = 0;
    int         cyc = 0, hold = 0, stall_len = 0;
    int         rd_cnt, beats, done_cnt, done_cyc, hs_cyc;
    logic [3:0] pat = 4'b1111;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr_counts();
        rd_cnt = 0; beats = 0; done_cnt = 0; done_cyc = -1; hs_cyc = -1;
    endtask

    task automatic push_frame(input int h, input int v, input logic [DW-1:0] base);
        beat_t b;
        for (int i = 0; i < h * v; i++) begin
            fifo_q.push_back(base + DW'(i));
            b.d = base + DW'(i);
            b.u = (i == 0);
            b.l = ((i % h) == h - 1);
            exp_q.push_back(b);
        end
    endtask

    // One clock: drive at negedge, sample #1 later, act on the upcoming posedge.
    task automatic cycle(input bit start, input bit abort);
        beat_t got;
        @(negedge clk);
        frame_start   = start;
        frame_abort   = abort;
        m_axis_tready = pat[cyc % 4];
        fifo_empty    = (hold > 0) || (fifo_q.size() == 0);
        fifo_dout     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        if (hold > 0) hold--;
        #1;
        if (fifo_rd_en) begin
            if (fifo_empty) chk("rd_en_while_empty", 1, 0);
            else begin
                void'(fifo_q.pop_front());
                rd_cnt++;
                if (rd_cnt == 1 && stall_len > 0) hold = stall_len;
            end
        end
        if (m_axis_tvalid) begin
            got = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
            if (exp_q.size() == 0) chk("extra_beat", {38'd0, got}, 64'd0);
            else begin
                chk("beat", {38'd0, got}, {38'd0, exp_q[0]});
                if (m_axis_tready) begin
                    void'(exp_q.pop_front());
                    beats++;
                    hs_cyc = cyc;
                end
            end
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic run_frame(input vec_t v);
        int budget = 0;
        clr_counts();
        pat = v.pat;
        stall_len = v.stall;
        hres = 12'(v.h);
        vres = 12'(v.v);
        push_frame(v.h, v.v, v.base);
        cycle(1, 0);
        while (done_cnt == 0 && budget < 300) begin
            cycle(0, 0);
            budget++;
        end
        cycle(0, 0);
        chk("frame_beats", beats, v.h * v.v);
        chk("frame_rd_cnt", rd_cnt, v.h * v.v);
        chk("frame_done_cnt", done_cnt, 1);
        chk("frame_done_timing", done_cyc, hs_cyc + 1);
        chk("frame_left", exp_q.size(), 0);
        chk("frame_underrun", underrun, v.exp_ur);
        chk("frame_busy_after", busy, 0);
        stall_len = 0;
    endtask

    initial begin
        int budget;
        vecs[0] = '{h: 4, v: 2, pat: 4'b1111, stall: 0, exp_ur: 1'b0, base: 24'h01};
        vecs[1] = '{h: 4, v: 2, pat: 4'b1001, stall: 0, exp_ur: 1'b0, base: 24'h11};
        vecs[2] = '{h: 3, v: 1, pat: 4'b1111, stall: 5, exp_ur: 1'b1, base: 24'h21};
        vecs[3] = '{h: 2, v: 3, pat: 4'b1111, stall: 0, exp_ur: 1'b0, base: 24'h31};
        vecs[4] = '{h: 5, v: 2, pat: 4'b0110, stall: 0, exp_ur: 1'b0, base: 24'h41};

        reset_rclk_top = 1'b0;
        frame_start = 0; frame_abort = 0; hres = 0; vres = 0;
        fifo_empty = 1; fifo_dout = 0; m_axis_tready = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_outs", {m_axis_tdata, m_axis_tuser, m_axis_tlast, busy, frame_done, underrun}, 0);
        @(negedge clk);
        reset_rclk_top = 1'b1;

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // hres==0: no beats, no pops, immediate done, never busy
        clr_counts();
        pat = 4'b1111;
        hres = 0; vres = 2;
        fifo_q.push_back(24'hAA);
        fifo_q.push_back(24'hBB);
        cycle(1, 0);
        chk("zero_done_early", frame_done, 0);
        cycle(0, 0);
        chk("zero_done", frame_done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_tvalid", m_axis_tvalid, 0);
        cycle(0, 0);
        chk("zero_done_clear", frame_done, 0);
        chk("zero_rd_cnt", rd_cnt, 0);
        fifo_q.delete();

        // abort an 8x4 frame after 10 beats
        clr_counts();
        hres = 8; vres = 4;
        push_frame(8, 4, 24'h100);
        cycle(1, 0);
        budget = 0;
        while (beats < 10 && budget < 100) begin
            cycle(0, 0);
            budget++;
        end
        chk("abort_beats_before", beats, 10);
        cycle(0, 1);
        cycle(0, 0);
        chk("abort_tvalid", m_axis_tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", fifo_rd_en, 0);
        repeat (3) cycle(0, 0);
        chk("abort_no_done", done_cnt, 0);
        fifo_q.delete();
        exp_q.delete();
        run_frame('{h: 2, v: 1, pat: 4'b1111, stall: 0, exp_ur: 1'b0, base: 24'h200});

        // async reset while a beat is stalled
        clr_counts();
        pat = 4'b0000;
        hres = 4; vres = 2;
        push_frame(4, 2, 24'h300);
        cycle(1, 0);
        repeat (3) cycle(0, 0);
        chk("rst_mid_tvalid_pre", m_axis_tvalid, 1);
        #2;
        reset_rclk_top = 1'b0;
        #1;
        chk("rst_mid_tvalid", m_axis_tvalid, 0);
        chk("rst_mid_outs", {m_axis_tdata, m_axis_tuser, m_axis_tlast, busy, frame_done, underrun}, 0);
        chk("rst_mid_rd_en", fifo_rd_en, 0);
        @(negedge clk);
        reset_rclk_top = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        fifo_q.push_back(24'hCC);
        pat = 4'b1111;
        cycle(0, 0);
        chk("rst_idle_rd_en", fifo_rd_en, 0);
        chk("rst_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vdma_fwft_axis_packer.md
Name: vdma_fwft_axis_packer

Overview:
- Read-side stage directly downstream of the VDMA FWFT FIFO wrapper.
- Pops pixels from the FWFT output (data valid whenever not empty) and emits an AXI4-Stream video frame.
- Marks frame start on tuser and end of line on tlast, using programmed horizontal and vertical resolution counters.
- Provides one output register stage with correct backpressure handling, plus frame-done and underrun status for the VDMA control logic.

Parameters:
- DWIDTH, 24, pixel data width; must match the FWFT read width.
- HBITS, 12, width of the horizontal resolution and pixel counter.
- VBITS, 12, width of the vertical resolution and line counter.

Ports:
- clk  input  1  single block clock; all logic on posedge.
- reset_rclk_top  input  1  asynchronous active-low reset.
- frame_start  input  1  one-cycle pulse; arms one frame transfer.
- frame_abort  input  1  one-cycle pulse; abandons the current frame.
- hres  input  HBITS  pixels per line; sampled on an accepted frame_start.
- vres  input  VBITS  lines per frame; sampled on an accepted frame_start.
- fifo_empty  input  1  FWFT empty; fifo_dout is valid when low.
- fifo_dout  input  DWIDTH  FWFT head-of-queue pixel.
- fifo_rd_en  output  1  active-high pop of the FWFT head.
- m_axis_tdata  output  DWIDTH  pixel data.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tuser  output  1  first pixel of the frame.
- m_axis_tlast  output  1  last pixel of the line.
- busy  output  1  high in ACTIVE or DRAIN.
- frame_done  output  1  one-cycle pulse when the frame completes.
- underrun  output  1  sticky; FIFO ran dry mid-frame.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, counters 0, latched hres/vres 0.
- States: IDLE, ACTIVE, DRAIN.
- Transition rules:
  - IDLE -> ACTIVE: frame_start=1 with hres!=0 and vres!=0. Latch hres/vres, clear hcnt, vcnt and underrun.
  - frame_start in IDLE with hres==0 or vres==0: no beats; frame_done pulses the next cycle; state stays IDLE.
  - frame_start outside IDLE is ignored.
- Load condition: ld = (state==ACTIVE) & !fifo_empty & (!m_axis_tvalid | m_axis_tready).
  - fifo_rd_en = ld, combinational.
  - On ld, the output register takes fifo_dout, and tvalid is set next cycle.
  - Latency: fifo pop in cycle N gives the beat visible in cycle N+1.
- If tvalid=1 and tready=1 and ld=0, tvalid clears.
- AXI rules: once tvalid=1, tdata, tuser and tlast hold until tready=1. Zero-bubble throughput when the FIFO is non-empty and tready is held high.
- Field values on each load:
  - tuser = (hcnt==0 & vcnt==0).
  - tlast = (hcnt==hres_l-1).
  - hcnt increments. At hres_l-1, hcnt wraps to 0 and vcnt increments.
- When the loaded pixel has hcnt==hres_l-1 and vcnt==vres_l-1: ACTIVE -> DRAIN. No further fifo_rd_en in DRAIN or IDLE.
- DRAIN -> IDLE when the final beat is accepted (tvalid & tready). frame_done pulses in the cycle after acceptance.
- Underrun: set when state==ACTIVE, at least one pixel has been loaded in this frame, fifo_empty=1, and the output register is empty or being emptied. It is sticky until the next accepted frame_start or reset. Transfer does not stop; it resumes when data arrives.
- frame_abort, in any state:
  - next cycle: state=IDLE, tvalid=0, counters cleared, no frame_done.
  - Abort takes priority over a simultaneous load or frame_start.
- Counter arithmetic is unsigned modulo width. hres_l/vres_l are held constant for the frame; input changes are ignored until the next frame_start.
- Async reset mid-frame behaves as an abort; there is no partial-frame recovery.

Test Plan:
- 4x2 frame, FIFO preloaded with 8 pixels 0x01..0x08, tready=1 -> 8 consecutive beats.
  - tuser only on 0x01; tlast on 0x04 and 0x08.
  - frame_done one cycle after the 0x08 handshake; underrun=0.
- Same 4x2 frame with tready toggling 1,0,0,1 -> tdata/tuser/tlast stable while stalled.
  - Exactly 8 beats, no duplicates, fifo_rd_en count=8.
- 3x1 frame, FIFO empty for 5 cycles after the first pixel -> underrun=1 and stays 1.
  - Remaining pixels are delivered when data arrives; frame_done pulses; the next frame_start clears underrun.
- frame_start with hres=0, vres=2 -> no tvalid, no fifo_rd_en; frame_done one cycle later; busy stays 0.
- 8x4 frame, frame_abort after 10 beats -> tvalid=0 and busy=0 next cycle, no frame_done.
  - A following 2x1 frame emits tuser on its first pixel.
- Assert reset_rclk_top low mid-beat with tvalid=1 -> all outputs 0 immediately, state IDLE.
